// File: rtl/imem_fetch_initiator.sv
// imem_fetch_initiator
//   Requester end of the mem_itf instruction port. Issues one aligned 32-bit
//   read per instruction, with at most one request outstanding. Returned words
//   are buffered with their PC in a small FIFO, and the FIFO head is offered to
//   decode over a valid/ready handshake. A redirect replaces the fetch PC,
//   flushes the FIFO and drops any response still in flight.
//
// Parameters
//   RESET_PC  PC of the first fetch after reset
//   DEPTH     instruction FIFO entries (power of 2, >= 2)
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   imem_addr       read address (word aligned, registered)
//   imem_rmask      4'hF for one cycle per request, else 4'h0 (registered)
//   imem_rdata      read data, valid with imem_resp
//   imem_resp       one-cycle response strobe per request
//   redirect_valid  load redirect_pc as the new fetch PC this cycle
//   redirect_pc     new fetch PC (low two bits ignored)
//   inst_valid      FIFO head holds an instruction
//   inst_ready      decode takes the head this cycle
//   inst, inst_pc   instruction word at the FIFO head and its PC
module imem_fetch_initiator #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    S_REQ,
    S_WAIT
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   addr_q;
  logic [3:0]    rmask_q;
  logic          discard;

  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   redirect_aligned;
  logic          push;
  logic          pop;

  // Low address bits are forced to zero regardless of what the caller sends.
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  // A redirect kills both the incoming word and any pop in the same cycle.
  assign push = (state == S_WAIT) && imem_resp && !discard && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  assign imem_addr  = addr_q;
  assign imem_rmask = rmask_q;
  assign inst_valid = (count != '0);
  assign inst       = fifo_inst[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

  // Request FSM, fetch PC and the stale-response discard flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      addr_q  <= RESET_PC;
      rmask_q <= '0;
      discard <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          // Room is judged on the pre-flush count; a redirect in the same
          // cycle only changes the address the request goes to.
          if (count < FULL) begin
            rmask_q <= 4'hF;
            addr_q  <= redirect_valid ? redirect_aligned : pc;
            state   <= S_WAIT;
          end else begin
            rmask_q <= '0;
          end
          if (redirect_valid) begin
            pc <= redirect_aligned;
          end
        end
        S_WAIT: begin
          rmask_q <= '0;
          if (imem_resp) begin
            // The response that arrives with a redirect is itself the stale
            // one, so nothing is left to discard afterwards.
            state   <= S_REQ;
            discard <= 1'b0;
            if (redirect_valid) begin
              pc <= redirect_aligned;
            end else if (!discard) begin
              pc <= pc + 32'd4;
            end
          end else if (redirect_valid) begin
            pc      <= redirect_aligned;
            discard <= 1'b1;
          end
        end
        default: begin
          state   <= S_REQ;
          rmask_q <= '0;
        end
      endcase
    end
  end

  // Instruction FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (push) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= pc;
    end
  end

endmodule

// File: tb/tb_imem_fetch_initiator.sv
module tb_imem_fetch_initiator;

  localparam logic [31:0] RPC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total    = 0;

  logic [31:0] exp_pc_q[$];
  int          lat = 0;
  int          pend = -1;
  logic [31:0] pend_addr;
  int          req_cnt = 0;
  logic [31:0] last_req_addr;
  logic [31:0] first_req_addr;
  logic [8:0]  pat;

  imem_fetch_initiator #(
    .RESET_PC(RPC),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata),
    .imem_resp(imem_resp),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory model reacts to the request visible now, the consumer
  // scoreboard checks any head that will be taken at the coming edge.
  task automatic cycle();
    logic [31:0] e;
    if (imem_rmask == 4'hF) begin
      req_cnt++;
      last_req_addr = imem_addr;
      if (req_cnt == 1) first_req_addr = imem_addr;
      pend      = lat;
      pend_addr = imem_addr;
    end
    if (pend == 0) begin
      imem_resp  = 1'b1;
      imem_rdata = word_of(pend_addr);
      pend       = -1;
    end else if (pend > 0) begin
      pend--;
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      check("pop_expected", 32'(exp_pc_q.size() != 0), 32'd1);
      if (exp_pc_q.size() != 0) begin
        e = exp_pc_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst", inst, word_of(e));
      end
    end
    @(posedge clk);
    #1;
    imem_resp = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_pc_q.size() == 0) break;
      cycle();
    end
    check(tag, 32'(exp_pc_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    imem_resp      = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    pend           = -1;
    req_cnt        = 0;
    exp_pc_q.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    rst = 1'b1;
    imem_resp = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    #12;
    check("rst_rmask", 32'(imem_rmask), 32'h0);
    check("rst_addr", imem_addr, RPC);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // 1: streaming with a 1-cycle memory, request every second cycle
    do_reset();
    inst_ready = 1'b1;
    lat = 0;
    for (int k = 0; k < 4; k++) exp_pc_q.push_back(RPC + 32'(4 * k));
    pat = '0;
    for (int i = 0; i < 9; i++) begin
      pat = {pat[7:0], imem_rmask == 4'hF};
      cycle();
    end
    check("t1_rmask_pattern", 32'(pat), 32'b010101010);
    check("t1_req_cnt", 32'(req_cnt), 32'd4);
    check("t1_drained", 32'(exp_pc_q.size()), 32'd0);

    // 2: decode stalled, FIFO fills to DEPTH and requests stop
    do_reset();
    lat = 0;
    for (int k = 0; k < 4; k++) exp_pc_q.push_back(RPC + 32'(4 * k));
    for (int i = 0; i < 20; i++) cycle();
    check("t2_req_cnt_full", 32'(req_cnt), 32'd4);
    check("t2_rmask_idle", 32'(imem_rmask), 32'h0);
    check("t2_valid", 32'(inst_valid), 32'd1);
    check("t2_head_pc", inst_pc, RPC);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("t2_req_cnt_after_pop", 32'(req_cnt), 32'd5);
    check("t2_refill_addr", last_req_addr, RPC + 32'd16);
    exp_pc_q.push_back(RPC + 32'd16);
    inst_ready = 1'b1;
    drain("t2_drained", 30);

    // 3: redirect while waiting on a slow response, FIFO holding one entry
    do_reset();
    lat = 2;
    for (int i = 0; i < 6; i++) cycle();
    check("t3_valid_before", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h1000;
    cycle();
    redirect_valid = 1'b0;
    check("t3_flushed", 32'(inst_valid), 32'd0);
    req_cnt = 0;
    cycle();
    check("t3_resp_dropped", 32'(inst_valid), 32'd0);
    exp_pc_q.push_back(32'h1000);
    exp_pc_q.push_back(32'h1004);
    inst_ready = 1'b1;
    drain("t3_drained", 30);
    check("t3_first_addr", first_req_addr, 32'h1000);

    // 4: redirect coinciding with a response and a pop
    do_reset();
    lat = 0;
    for (int i = 0; i < 3; i++) cycle();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h2000;
    check("t4_resp_now", 32'(imem_rmask), 32'hF);
    check("t4_valid_now", 32'(inst_valid), 32'd1);
    cycle();
    redirect_valid = 1'b0;
    check("t4_flushed", 32'(inst_valid), 32'd0);
    check("t4_no_req_yet", 32'(imem_rmask), 32'h0);
    req_cnt = 0;
    exp_pc_q.push_back(32'h2000);
    drain("t4_drained", 20);
    check("t4_first_addr", first_req_addr, 32'h2000);

    // 5: PC wraps from the top of the address space
    do_reset();
    lat = 0;
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_pc_q.push_back(32'hFFFF_FFFC);
    exp_pc_q.push_back(32'h0000_0000);
    exp_pc_q.push_back(32'h0000_0004);
    cycle();
    redirect_valid = 1'b0;
    drain("t5_drained", 20);
    check("t5_first_addr", first_req_addr, 32'hFFFF_FFFC);

    // 6: reset during S_WAIT, late response after release is ignored
    do_reset();
    inst_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t6_req", 32'(imem_rmask), 32'hF);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_rmask", 32'(imem_rmask), 32'h0);
    check("t6_async_addr", imem_addr, RPC);
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_resp = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    imem_resp = 1'b0;
    check("t6_late_ignored", 32'(inst_valid), 32'd0);
    check("t6_reissue_rmask", 32'(imem_rmask), 32'hF);
    check("t6_reissue_addr", imem_addr, RPC);
    imem_resp = 1'b1;
    imem_rdata = word_of(RPC);
    inst_ready = 1'b0;
    @(posedge clk);
    #1;
    imem_resp = 1'b0;
    check("t6_valid", 32'(inst_valid), 32'd1);
    check("t6_inst", inst, word_of(RPC));
    check("t6_inst_pc", inst_pc, RPC);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
